median_window_feeder: RTL and testbench

- Transmit-side companion to the 9-sample median sorter.
- Consumes a raster pixel stream, keeps two line buffers, and forms 3x3 neighbourhoods (valid region only, no border padding).
- Serialises each window as a 9-beat d_en burst, then holds d_en low for a fixed gap so the sorter can sort and drain before the next burst.
- Throttles the upstream pixel source with pix_ready.

---
 rtl/median_window_feeder.sv | 134 +++++++++++++
 tb/tb_median_window_feeder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/median_window_feeder.sv
// Raster-to-window feeder for the 9-sample median sorter: two line buffers build 3x3
// neighbourhoods, each sent as a 9-beat d_en burst followed by a fixed idle gap.
module median_window_feeder #(
  parameter int unsigned S     = 8,
  parameter int unsigned IMG_W = 16,
  parameter int unsigned GAP   = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [S-1:0] pix_in,
  input  logic         pix_valid,
  input  logic         sof,
  output logic         pix_ready,
  output logic         d_en,
  output logic [S-1:0] data_out,
  output logic [15:0]  win_cnt
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned GW = $clog2(GAP + 1);

  typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  col_q, col_eff;
  logic [1:0]     row_q, row_eff;
  logic [3:0]     beat_q;
  logic [GW-1:0]  gap_q;
  logic           d_en_q;
  logic [S-1:0]   data_out_q;
  logic [15:0]    win_cnt_q;

  logic [S-1:0]   lb1 [IMG_W];
  logic [S-1:0]   lb2 [IMG_W];
  // Column shift register, index 0 = top (row r-2), 2 = bottom (row r).
  logic [S-1:0]   colm2_q [3];
  logic [S-1:0]   colm1_q [3];
  logic [S-1:0]   cur_col [3];
  logic [S-1:0]   txbuf_q [9];

  logic accept, win_done, burst_last, gap_last, col_wrap;

  // An accepted sof pixel is treated as (0,0) regardless of the running counters.
  assign accept     = pix_valid && pix_ready;
  assign col_eff    = sof ? '0 : col_q;
  assign row_eff    = sof ? '0 : row_q;
  assign col_wrap   = (col_eff == CW'(IMG_W - 1));
  assign win_done   = accept && (row_eff == 2'd2) && (col_eff >= CW'(2));
  assign burst_last = (state_q == StSend) && (beat_q == 4'd8);
  assign gap_last   = (state_q == StGap) && (gap_q == GW'(GAP - 1));

  always_comb begin
    cur_col[0] = lb2[col_eff];
    cur_col[1] = lb1[col_eff];
    cur_col[2] = pix_in;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (win_done)   state_d = StSend;
      StSend:  if (burst_last) state_d = StGap;
      StGap:   if (gap_last)   state_d = StIdle;
      default:                 state_d = StIdle;
    endcase
  end

  always_comb begin
    pix_ready = (state_q == StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q      <= '0;
      row_q      <= '0;
      beat_q     <= '0;
      gap_q      <= '0;
      d_en_q     <= 1'b0;
      data_out_q <= '0;
      win_cnt_q  <= '0;
    end else begin
      if (accept) begin
        col_q <= col_wrap ? '0 : col_eff + CW'(1);
        row_q <= (col_wrap && row_eff != 2'd2) ? row_eff + 2'd1 : row_eff;
        if (sof) win_cnt_q <= '0;
      end
      if (win_done) begin
        d_en_q     <= 1'b1;
        data_out_q <= colm2_q[0];
        beat_q     <= '0;
      end
      if (state_q == StSend) begin
        if (burst_last) begin
          d_en_q    <= 1'b0;
          win_cnt_q <= win_cnt_q + 16'd1;
          gap_q     <= '0;
        end else begin
          beat_q     <= beat_q + 4'd1;
          data_out_q <= txbuf_q[beat_q + 4'd1];
        end
      end
      if (state_q == StGap) gap_q <= gap_q + GW'(1);
    end
  end

  // Line buffers, column shift register and tx buffer carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb2[col_eff] <= lb1[col_eff];
      lb1[col_eff] <= pix_in;
      for (int i = 0; i < 3; i++) begin
        colm2_q[i] <= colm1_q[i];
        colm1_q[i] <= cur_col[i];
      end
    end
    if (win_done) begin
      for (int i = 0; i < 3; i++) begin
        txbuf_q[3*i]     <= colm2_q[i];
        txbuf_q[3*i + 1] <= colm1_q[i];
        txbuf_q[3*i + 2] <= cur_col[i];
      end
    end
  end

  assign d_en     = d_en_q;
  assign data_out = data_out_q;
  assign win_cnt  = win_cnt_q;

endmodule

// File: tb/tb_median_window_feeder.sv
// Scoreboard bench: a frame-array model predicts every 3x3 window; a monitor checks bursts.
module tb_median_window_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [7:0] pin  [2];
  logic       pv   [2];
  logic       psof [2];

  logic        a_rdy, a_den, b_rdy, b_den;
  logic [7:0]  a_dout, b_dout;
  logic [15:0] a_wc, b_wc;

  logic        rdy  [2];
  logic        den  [2];
  logic [7:0]  dout [2];
  logic [15:0] wc   [2];

  always_comb begin
    rdy[0] = a_rdy;  den[0] = a_den;  dout[0] = a_dout;  wc[0] = a_wc;
    rdy[1] = b_rdy;  den[1] = b_den;  dout[1] = b_dout;  wc[1] = b_wc;
  end

  median_window_feeder #(.S(8), .IMG_W(4), .GAP(3)) dut_a (
    .clk(clk), .reset(reset), .pix_in(pin[0]), .pix_valid(pv[0]), .sof(psof[0]),
    .pix_ready(a_rdy), .d_en(a_den), .data_out(a_dout), .win_cnt(a_wc)
  );

  median_window_feeder #(.S(8), .IMG_W(16), .GAP(12)) dut_b (
    .clk(clk), .reset(reset), .pix_in(pin[1]), .pix_valid(pv[1]), .sof(psof[1]),
    .pix_ready(b_rdy), .d_en(b_den), .data_out(b_dout), .win_cnt(b_wc)
  );

  int wid [2] = '{4, 16};
  int gap [2] = '{3, 12};

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [87:0] act, input logic [87:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: whole frame kept as a 2-D array, windows read straight out of it.
  logic [7:0]  img [2][64][16];
  int          mr [2], mc [2];
  logic [15:0] mw [2];
  logic [87:0] q0 [$];
  logic [87:0] q1 [$];
  int          pres [2], acc [2], bursts [2];

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  task automatic model_accept(input int k, input logic [7:0] p, input logic s);
    logic [71:0] v;
    if (s) begin mr[k] = 0; mc[k] = 0; mw[k] = '0; end
    img[k][mr[k]][mc[k]] = p;
    if (mr[k] >= 2 && mc[k] >= 2) begin
      v = '0;
      for (int dr = 2; dr >= 0; dr--)
        for (int dc = 2; dc >= 0; dc--)
          v = {v[63:0], img[k][mr[k]-dr][mc[k]-dc]};
      mw[k] = mw[k] + 16'd1;
      if (k == 0) q0.push_back({mw[k], v});
      else        q1.push_back({mw[k], v});
    end
    mc[k]++;
    if (mc[k] == wid[k]) begin mc[k] = 0; if (mr[k] < 63) mr[k]++; end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin mr[k] = 0; mc[k] = 0; mw[k] = '0; end
    q0.delete();
    q1.delete();
  endtask

  task automatic pulse_reset(input int cycles);
    reset = 1'b1;
    model_reset();
    repeat (cycles) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Present one pixel and hold it (valid high) until accepted.
  task automatic send(input int k, input logic [7:0] p, input logic s, input bit gaps,
                      output int waited);
    if (gaps && $urandom_range(0, 3) == 0) begin
      pv[k]  = 1'b0;
      pin[k] = 8'($urandom);
      repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
    end
    pin[k] = p; pv[k] = 1'b1; psof[k] = s; waited = 0;
    while (!rdy[k] && waited < 200) begin @(posedge clk); #1; waited++; end
    if (!rdy[k]) chk("accept_timeout", 88'(rdy[k]), 88'(1));
    model_accept(k, p, s);
    pres[k]++;
    @(posedge clk); #1;
    pv[k] = 1'b0; psof[k] = 1'b0;
  endtask

  task automatic drain(input int k);
    int n = 0;
    while ((qsize(k) != 0 || !rdy[k] || den[k]) && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_queue_empty", 88'(qsize(k)), 88'(0));
  endtask

  // Monitor
  logic [71:0] cur [2];
  int          beats [2], lowrun [2], rcnt [2];
  bit          had [2], ract [2], pden [2];

  always @(negedge clk) begin
    logic [87:0] e;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        beats[k] = 0; had[k] = 0; ract[k] = 0; pden[k] = 0; cur[k] = '0; lowrun[k] = 0;
      end else begin
        if (pv[k] && rdy[k]) acc[k]++;
        if (den[k] && !pden[k]) begin
          if (had[k]) chk("gap_len_min", 88'(lowrun[k] >= gap[k]), 88'(1));
          ract[k] = 1; rcnt[k] = 0;
        end
        if (ract[k]) begin
          rcnt[k]++;
          if (rdy[k]) begin chk("ready_return", 88'(rcnt[k]), 88'(10 + gap[k])); ract[k] = 0; end
        end
        if (den[k]) begin
          cur[k] = {cur[k][63:0], dout[k]};
          beats[k]++;
          lowrun[k] = 0;
        end else begin
          if (beats[k] > 0) begin
            bursts[k]++;
            chk("burst_len", 88'(beats[k]), 88'(9));
            if (qsize(k) == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_burst: got %0h expected none", cur[k]);
            end else begin
              e = (k == 0) ? q0.pop_front() : q1.pop_front();
              chk("burst_data", 88'(cur[k]), 88'(e[71:0]));
              chk("burst_win_cnt", 88'(wc[k]), 88'(e[87:72]));
            end
            had[k] = 1; beats[k] = 0;
          end
          lowrun[k]++;
        end
        pden[k] = den[k];
      end
    end
  end

  initial begin
    int w;
    for (int k = 0; k < 2; k++) begin
      pin[k] = '0; pv[k] = 1'b0; psof[k] = 1'b0; pres[k] = 0; acc[k] = 0; bursts[k] = 0;
    end
    pulse_reset(3);
    for (int k = 0; k < 2; k++) begin
      chk("reset_pix_ready", 88'(rdy[k]), 88'(1));
      chk("reset_d_en", 88'(den[k]), 88'(0));
      chk("reset_data_out", 88'(dout[k]), 88'(0));
      chk("reset_win_cnt", 88'(wc[k]), 88'(0));
    end

    // Frame of P=10r+c up to (3,2); (3,0)/(3,1) must go back-to-back.
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!(r == 3 && c == 3)) begin
          send(0, 8'(10*r + c), r == 0 && c == 0, !(r == 3 && c == 1), w);
          if (r == 3 && c == 1) chk("back_to_back", 88'(w), 88'(0));
        end
    drain(0);
    chk("win_cnt_after_frame", 88'(wc[0]), 88'(3));

    // Reset on the 5th beat of the first burst.
    pulse_reset(1);
    for (int i = 0; i < 11; i++) send(0, 8'(10*(i/4) + i%4), 1'b0, 1'b1, w);
    repeat (4) begin @(posedge clk); #1; end
    chk("pre_reset_d_en", 88'(den[0]), 88'(1));
    pulse_reset(1);
    chk("mid_burst_reset_d_en", 88'(den[0]), 88'(0));
    chk("mid_burst_reset_win_cnt", 88'(wc[0]), 88'(0));
    chk("mid_burst_reset_ready", 88'(rdy[0]), 88'(1));

    // Restream, then sof at (3,1) starts a fresh frame of random pixels.
    for (int i = 0; i < 13; i++) send(0, 8'(10*(i/4) + i%4), 1'b0, 1'b1, w);
    send(0, 8'($urandom), 1'b1, 1'b0, w);
    chk("sof_clears_win_cnt", 88'(wc[0]), 88'(0));
    for (int i = 0; i < 15; i++) send(0, 8'($urandom), 1'b0, 1'b1, w);
    drain(0);
    chk("win_cnt_after_sof", 88'(wc[0]), 88'(4));

    // Wide configuration: 16x5 frame of random pixels.
    pulse_reset(2);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 16; c++)
        send(1, 8'($urandom), r == 0 && c == 0, 1'b1, w);
    drain(1);
    chk("wide_burst_count", 88'(bursts[1]), 88'(42));
    chk("wide_win_cnt", 88'(wc[1]), 88'(42));
    for (int k = 0; k < 2; k++) chk("accepted_eq_presented", 88'(acc[k]), 88'(pres[k]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
